// File: rtl/io_burst_seq_pkg.sv
// Shared types for the DDR3 BL8 burst sequencer: FSM states and address bit positions.
`include "define.sv"

package io_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LAT,
        PRE,
        BURST,
        POST,
        TURN
    } state_t;

    // A10 = auto-precharge select, A12 = burst-chop select (1 -> fixed BL8)
    localparam int A10_BIT = 10;
    localparam int A12_BIT = 12;

endpackage

// File: rtl/io_burst_seq_if.sv
// User-side command/response bus of the burst sequencer.
`include "define.sv"

interface io_burst_seq_if;

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_wr;
    logic [`BA_BITS-1:0]       cmd_ba;
    logic [`ADDR_BITS-1:0]     cmd_addr;
    logic [`DQ_BITS*8-1:0]     cmd_wdata;
    logic [`DQ_BITS*8-1:0]     rdata;
    logic                      rdata_valid;

    modport master (
        output cmd_valid, cmd_wr, cmd_ba, cmd_addr, cmd_wdata,
        input  cmd_ready, rdata, rdata_valid
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_ba, cmd_addr, cmd_wdata,
        output cmd_ready, rdata, rdata_valid
    );

endinterface

// File: rtl/define.sv
// Bus widths shared by the burst sequencer, its interface and the testbench.
`ifndef IO_SEQ_DEFINE_SV
`define IO_SEQ_DEFINE_SV
`define BA_BITS   3
`define ADDR_BITS 14
`define DQ_BITS   8
`define DM_BITS   1
`define DQS_BITS  1
`endif

// File: rtl/io_burst_seq_lat_cnt.sv
// Loadable 4-bit down-counter with zero flag; times the latency and turnaround phases.
module io_lat_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/io_burst_seq.sv
// DDR3 BL8 burst sequencer: issues one READ/WRITE command, times CL/CWL, and
// drives or captures the eight data beats, then idles T_TURN cycles.
`include "define.sv"

module io_burst_seq
    import io_seq_pkg::*;
#(
    parameter int CL     = 5,
    parameter int CWL    = 5,
    parameter int T_TURN = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    io_burst_seq_if.slave          bus,
    output logic                   ddr3_cs_n,
    output logic                   ddr3_ras_n,
    output logic                   ddr3_cas_n,
    output logic                   ddr3_we_n,
    output logic [`BA_BITS-1:0]    ddr3_ba,
    output logic [`ADDR_BITS-1:0]  ddr3_addr,
    output logic                   ddr3_rw,
    output logic [`DQ_BITS-1:0]    ddr3_data_out,
    input  logic [`DQ_BITS-1:0]    ddr3_data_in,
    output logic [`DM_BITS-1:0]    ddr3_dm_tdqs_out,
    output logic [`DQS_BITS-1:0]   ddr3_dqs_out,
    output logic [`DQS_BITS-1:0]   ddr3_dqs_n_out
);

    localparam int DQ = `DQ_BITS;
    localparam int BW = DQ * 8;

    // LAT lasts load+1 cycles: CWL-2 for writes (PRE follows), CL-1 for reads
    localparam logic [3:0] WR_LOAD   = (CWL > 2) ? 4'(CWL - 3) : 4'd0;
    localparam logic [3:0] RD_LOAD   = 4'(CL - 2);
    localparam logic [3:0] TURN_LOAD = 4'(T_TURN - 1);

    state_t                 state, state_nxt;
    logic                   wr_q;
    logic [`BA_BITS-1:0]    ba_q;
    logic [`ADDR_BITS-1:0]  addr_q;
    logic [BW-1:0]          wdata_q;
    logic [2:0]             beat_q;
    logic [BW-1:0]          rd_shadow;
    logic [BW-1:0]          rdata_q;
    logic                   rdata_valid_q;
    logic                   cnt_load;
    logic [3:0]             cnt_val;
    logic                   cnt_dec;
    logic                   cnt_zero;
    logic                   accept;
    logic                   wr_burst;

    function automatic logic [`ADDR_BITS-1:0] addr_bl8(input logic [`ADDR_BITS-1:0] a);
        logic [`ADDR_BITS-1:0] r;
        r          = a;
        r[A10_BIT] = 1'b0;
        r[A12_BIT] = 1'b1;
        return r;
    endfunction

    io_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign accept = (state == IDLE) && bus.cmd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = 4'd0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE:  if (bus.cmd_valid) state_nxt = CMD;
            CMD: begin
                if (wr_q && (CWL == 2)) begin
                    state_nxt = PRE;
                end else begin
                    state_nxt = LAT;
                    cnt_load  = 1'b1;
                    cnt_val   = wr_q ? WR_LOAD : RD_LOAD;
                end
            end
            LAT: begin
                if (cnt_zero) state_nxt = wr_q ? PRE : BURST;
                else          cnt_dec   = 1'b1;
            end
            PRE:   state_nxt = BURST;
            BURST: begin
                if (beat_q == 3'd7) begin
                    if (wr_q) begin
                        state_nxt = POST;
                    end else begin
                        state_nxt = TURN;
                        cnt_load  = 1'b1;
                        cnt_val   = TURN_LOAD;
                    end
                end
            end
            POST: begin
                state_nxt = TURN;
                cnt_load  = 1'b1;
                cnt_val   = TURN_LOAD;
            end
            TURN: begin
                if (cnt_zero) state_nxt = IDLE;
                else          cnt_dec   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, beat counter and read capture; rdata only changes when a read completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q          <= 1'b0;
            ba_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            beat_q        <= 3'd0;
            rd_shadow     <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            if (accept) begin
                wr_q    <= bus.cmd_wr;
                ba_q    <= bus.cmd_ba;
                addr_q  <= addr_bl8(bus.cmd_addr);
                wdata_q <= bus.cmd_wdata;
            end
            if (state == BURST) begin
                beat_q <= beat_q + 3'd1;
                if (!wr_q) begin
                    rd_shadow[beat_q*DQ +: DQ] <= ddr3_data_in;
                    if (beat_q == 3'd7) begin
                        rdata_q       <= {ddr3_data_in, rd_shadow[7*DQ-1:0]};
                        rdata_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign wr_burst = (state == BURST) && wr_q;

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;

    assign ddr3_cs_n  = (state != CMD);
    assign ddr3_ras_n = 1'b1;
    assign ddr3_cas_n = (state != CMD);
    assign ddr3_we_n  = (state == CMD) ? ~wr_q : 1'b1;
    assign ddr3_ba    = ba_q;
    assign ddr3_addr  = addr_q;

    // Pad drives only across the write PRE..POST window
    assign ddr3_rw = ~(wr_q && ((state == PRE) || (state == BURST) || (state == POST)));

    assign ddr3_data_out    = wr_burst ? wdata_q[beat_q*DQ +: DQ] : '0;
    assign ddr3_dqs_out     = (wr_burst && !beat_q[0]) ? '1 : '0;
    assign ddr3_dqs_n_out   = ~ddr3_dqs_out;
    assign ddr3_dm_tdqs_out = '0;

endmodule

// File: tb/tb_io_burst_seq.sv
// Randomised bench for io_burst_seq against a cycle-schedule reference model.
module tb_io_burst_seq;

    localparam int CL     = 5;
    localparam int CWL    = 5;
    localparam int T_TURN = 2;
    localparam int BA     = `BA_BITS;
    localparam int AW     = `ADDR_BITS;
    localparam int DQ     = `DQ_BITS;
    localparam int DMW    = `DM_BITS;
    localparam int DQSW   = `DQS_BITS;
    localparam int BW     = DQ * 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_burst_seq_if bus ();

    logic            cs_n, ras_n, cas_n, we_n, rw;
    logic [BA-1:0]   ddr_ba;
    logic [AW-1:0]   ddr_addr;
    logic [DQ-1:0]   data_out;
    logic [DQ-1:0]   data_in;
    logic [DMW-1:0]  dm;
    logic [DQSW-1:0] dqs_out, dqs_n_out;

    io_burst_seq #(.CL(CL), .CWL(CWL), .T_TURN(T_TURN)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .ddr3_cs_n        (cs_n),
        .ddr3_ras_n       (ras_n),
        .ddr3_cas_n       (cas_n),
        .ddr3_we_n        (we_n),
        .ddr3_ba          (ddr_ba),
        .ddr3_addr        (ddr_addr),
        .ddr3_rw          (rw),
        .ddr3_data_out    (data_out),
        .ddr3_data_in     (data_in),
        .ddr3_dm_tdqs_out (dm),
        .ddr3_dqs_out     (dqs_out),
        .ddr3_dqs_n_out   (dqs_n_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: the accepted command and the cycle its CMD appears on the pins
    int            t_cmd     = -100;
    bit            m_wr      = 1'b0;
    logic [BA-1:0] m_ba      = '0;
    logic [AW-1:0] m_addr    = '0;
    logic [BW-1:0] m_wdata   = '0;
    logic [BW-1:0] exp_rdata = '0;
    bit            a0_pattern = 1'b0;
    logic [DQ-1:0] din_hist [0:8191];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return cyc >= t_cmd + (m_wr ? (CWL + 9 + T_TURN) : (CL + 8 + T_TURN));
    endfunction

    function automatic logic [AW-1:0] bl8(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r     = a;
        r[10] = 1'b0;
        r[12] = 1'b1;
        return r;
    endfunction

    task automatic check_cycle();
        bit              is_cmd, wrw, wburst, rdone;
        int              k;
        logic [DQSW-1:0] dqs;
        logic [DQ-1:0]   dout;
        is_cmd = (cyc == t_cmd);
        k      = cyc - (t_cmd + CWL);
        wburst = m_wr && (k >= 0) && (k < 8);
        wrw    = m_wr && (cyc >= t_cmd + CWL - 1) && (cyc <= t_cmd + CWL + 8);
        dqs    = (wburst && (k % 2 == 0)) ? '1 : '0;
        dout   = '0;
        if (wburst) dout = m_wdata[k*DQ +: DQ];
        rdone  = !m_wr && (t_cmd >= 0) && (cyc == t_cmd + CL + 8);
        if (rdone)
            for (int b = 0; b < 8; b++) exp_rdata[b*DQ +: DQ] = din_hist[t_cmd + CL + b];
        check("cmd_pins", 128'({cs_n, ras_n, cas_n, we_n}),
              128'({~is_cmd, 1'b1, ~is_cmd, (is_cmd ? ~m_wr : 1'b1)}));
        check("ba_addr", 128'({ddr_ba, ddr_addr}), 128'({m_ba, m_addr}));
        check("rw", 128'(rw), 128'(!wrw));
        check("dq_out", 128'({dqs_out, dqs_n_out, dm, data_out}),
              128'({dqs, ~dqs, {DMW{1'b0}}, dout}));
        check("cmd_ready", 128'(bus.cmd_ready), 128'(m_ready()));
        check("rdata_valid", 128'(bus.rdata_valid), 128'(rdone));
        check("rdata", 128'(bus.rdata), 128'(exp_rdata));
    endtask

    task automatic tick(input bit v, input bit wr, input logic [BA-1:0] ba,
                        input logic [AW-1:0] addr, input logic [BW-1:0] wd, output bit accepted);
        int k;
        @(negedge clk);
        cyc++;
        check_cycle();
        k = cyc - (t_cmd + CL);
        if (a0_pattern && !m_wr && (k >= 0) && (k < 8)) data_in = DQ'(8'hA0 + k);
        else                                             data_in = DQ'($urandom);
        din_hist[cyc]   = data_in;
        bus.cmd_valid   = v;
        bus.cmd_wr      = wr;
        bus.cmd_ba      = ba;
        bus.cmd_addr    = addr;
        bus.cmd_wdata   = wd;
        accepted = v && m_ready();
        if (accepted) begin
            t_cmd   = cyc + 1;
            m_wr    = wr;
            m_ba    = ba;
            m_addr  = bl8(addr);
            m_wdata = wd;
        end
    endtask

    // Idle cycles carry random command fields with cmd_valid low
    task automatic idle(input int n);
        bit a;
        repeat (n) tick(1'b0, 1'($urandom), BA'($urandom), AW'($urandom),
                        BW'({$urandom, $urandom}), a);
    endtask

    task automatic issue(input bit wr, input logic [BA-1:0] ba, input logic [AW-1:0] addr,
                         input logic [BW-1:0] wd);
        bit a;
        int guard;
        a     = 1'b0;
        guard = 0;
        while (!a && guard < 200) begin
            tick(1'b1, wr, ba, addr, wd, a);
            guard++;
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_ba    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        data_in       = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        idle(3);
        // Write with A10=1/A12=0 in the request, beats 0x11..0x88
        issue(1'b1, 3'd5, 14'h0455, 64'h8877665544332211);
        idle(20);
        // Read with the pad returning 0xA0+k
        a0_pattern = 1'b1;
        issue(1'b0, 3'd2, 14'h1234, '0);
        idle(16);
        a0_pattern = 1'b0;
        // cmd_valid held across a write followed by a read
        issue(1'b1, 3'd1, 14'h2abc, 64'h0123456789abcdef);
        issue(1'b0, 3'd6, 14'h3fff, '0);
        idle(20);

        // Reset asserted during write beat 3
        issue(1'b1, 3'd7, 14'h1555, 64'hfedcba9876543210);
        while (cyc < t_cmd + CWL + 3) idle(1);
        rst_n = 1'b0;
        #1;
        t_cmd     = -100;
        m_wr      = 1'b0;
        m_ba      = '0;
        m_addr    = '0;
        m_wdata   = '0;
        exp_rdata = '0;
        check_cycle();
        idle(2);
        rst_n = 1'b1;
        idle(3);

        repeat (60) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 5));
            issue(1'($urandom), BA'($urandom), AW'($urandom), BW'({$urandom, $urandom}));
        end
        idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
